// File: rtl/fft_frame_exerciser.sv
// fft_frame_exerciser: framed stimulus generator and checksum drain for fft_computer
module fft_frame_exerciser #(
  parameter int          DATA_W     = 32,
  parameter int          FRAME_LEN  = 1024,
  parameter int          GAP_CYC    = 4,
  parameter int          LED_W      = 8,
  parameter logic [63:0] CONST_VAL  = 64'h0000_0000_0001_0000,
  parameter logic [7:0]  READY_MASK = 8'hFF,
  parameter int          TIMEOUT    = 65535
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [1:0]        i_mode,
  input  logic [15:0]       i_frames,
  output logic              o_stim_valid,
  output logic [DATA_W-1:0] o_stim_data,
  input  logic              i_stim_ready,
  input  logic              i_res_valid,
  input  logic [DATA_W-1:0] i_res_data,
  output logic              o_res_ready,
  output logic [LED_W-1:0]  o_led,
  output logic [15:0]       o_frame_cnt,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_timeout
);
  localparam int BW = $clog2(FRAME_LEN);
  localparam int GW = GAP_CYC > 1 ? $clog2(GAP_CYC) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} st_t;
  st_t              st;
  logic [BW-1:0]    beat, rbeat;
  logic [GW-1:0]    gcnt;
  logic [TW-1:0]    idle;
  logic [15:0]      sent, frames;
  logic [1:0]       mode;
  logic [DATA_W-1:0] ramp;
  logic [31:0]      lfsr, lfsr_nx;
  logic [LED_W-1:0] acc, r_sum;
  logic [2:0]       phase;
  logic             s_acc, r_acc, last_s, last_r;
  function automatic logic [LED_W-1:0] bsum(input logic [DATA_W-1:0] d);
    logic [LED_W-1:0] s;
    s = '0;
    for (int i = 0; i < DATA_W / 8; i++) s = s + LED_W'(d[8*i +: 8]);
    return s;
  endfunction
  assign lfsr_nx      = (lfsr >> 1) ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
  assign o_stim_valid = st == SEND;
  assign o_stim_data  = mode == 2'd0 ? ramp :
                        mode == 2'd1 ? DATA_W'(CONST_VAL) :
                        mode == 2'd2 ? (beat == '0 ? DATA_W'(CONST_VAL) : '0) :
                        DATA_W'(lfsr);
  assign o_res_ready  = o_busy & READY_MASK[phase];
  assign s_acc        = o_stim_valid & i_stim_ready;
  assign r_acc        = i_res_valid & o_res_ready & (o_frame_cnt != frames);
  assign r_sum        = acc + bsum(i_res_data);
  assign last_s       = beat == BW'(FRAME_LEN - 1);
  assign last_r       = rbeat == BW'(FRAME_LEN - 1);
  // run control, stimulus sequencing, result reduction and watchdog share one state machine
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st <= IDLE;
      beat <= '0;
      rbeat <= '0;
      gcnt <= '0;
      idle <= '0;
      sent <= '0;
      frames <= '0;
      mode <= '0;
      ramp <= '0;
      lfsr <= 32'h1;
      acc <= '0;
      phase <= '0;
      o_led <= '0;
      o_frame_cnt <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      phase <= phase + 3'd1;
      if (i_start && !o_busy) begin
        mode <= i_mode;
        frames <= i_frames;
        st <= i_frames != 16'd0 ? SEND : IDLE;
        o_busy <= i_frames != 16'd0;
        o_done <= i_frames == 16'd0;
        o_timeout <= 1'b0;
        o_frame_cnt <= '0;
        o_led <= '0;
        acc <= '0;
        ramp <= '0;
        lfsr <= 32'h1;
        beat <= '0;
        rbeat <= '0;
        sent <= '0;
        gcnt <= '0;
        idle <= '0;
      end else if (o_busy) begin
        if (st == FIN && o_frame_cnt == frames) begin
          o_busy <= 1'b0;
          o_done <= 1'b1;
          st <= IDLE;
        end else if (!s_acc && !r_acc && idle == TW'(TIMEOUT - 1)) begin
          o_busy <= 1'b0;
          o_done <= 1'b1;
          o_timeout <= 1'b1;
          st <= IDLE;
        end else begin
          idle <= (s_acc || r_acc) ? '0 : idle + TW'(1);
          if (s_acc) begin
            ramp <= ramp + DATA_W'(1);
            lfsr <= lfsr_nx;
            beat <= last_s ? '0 : beat + BW'(1);
            if (last_s) begin
              sent <= sent + 16'd1;
              st <= sent + 16'd1 == frames ? FIN : GAP_CYC == 0 ? SEND : GAP;
              gcnt <= '0;
            end
          end
          if (st == GAP) begin
            gcnt <= gcnt + GW'(1);
            if (gcnt == GW'(GAP_CYC - 1)) st <= SEND;
          end
          if (r_acc) begin
            acc <= last_r ? '0 : r_sum;
            rbeat <= last_r ? '0 : rbeat + BW'(1);
            if (last_r) begin
              o_led <= r_sum;
              o_frame_cnt <= o_frame_cnt + 16'd1;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_fft_frame_exerciser.sv
// tb_fft_frame_exerciser: directed scoreboard bench with pass-through result echo
module tb_fft_frame_exerciser;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;
  logic st_a = 1'b0, sr_a = 1'b1, st_b = 1'b0;
  logic [1:0] md_a = '0, md_b = '0;
  logic [15:0] fr_a = '0, fr_b = '0;
  logic sv_a, sri_a, rv_a, rr_a, busy_a, done_a, to_a;
  logic sv_b, rr_b, busy_b, done_b, to_b;
  logic [31:0] sd_a, sd_b;
  logic [7:0] led_a, led_b;
  logic [15:0] fc_a, fc_b;
  int n_cmp = 0, n_err = 0;
  logic [31:0] q_a[$], q_b[$];
  logic [7:0] l_a[$], l_b[$];
  logic pst_a, pb_b, prr_b;
  logic [31:0] pd_a;
  logic [15:0] pfc_a, pfc_b;
  // echo path: a beat enters and leaves the stand-in pipeline in the same cycle
  assign sri_a = sr_a & rr_a;
  assign rv_a  = sv_a & sr_a;
  fft_frame_exerciser #(.DATA_W(32), .FRAME_LEN(4), .GAP_CYC(2), .LED_W(8),
    .READY_MASK(8'hFF), .TIMEOUT(16)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(st_a), .i_mode(md_a), .i_frames(fr_a),
    .o_stim_valid(sv_a), .o_stim_data(sd_a), .i_stim_ready(sri_a),
    .i_res_valid(rv_a), .i_res_data(sd_a), .o_res_ready(rr_a),
    .o_led(led_a), .o_frame_cnt(fc_a), .o_busy(busy_a), .o_done(done_a), .o_timeout(to_a));
  fft_frame_exerciser #(.DATA_W(32), .FRAME_LEN(4), .GAP_CYC(0), .LED_W(8),
    .READY_MASK(8'b0101_0101), .TIMEOUT(16)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(st_b), .i_mode(md_b), .i_frames(fr_b),
    .o_stim_valid(sv_b), .o_stim_data(sd_b), .i_stim_ready(rr_b),
    .i_res_valid(sv_b), .i_res_data(sd_b), .o_res_ready(rr_b),
    .o_led(led_b), .o_frame_cnt(fc_b), .o_busy(busy_b), .o_done(done_b), .o_timeout(to_b));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] bsum(input logic [31:0] d);
    return d[7:0] + d[15:8] + d[23:16] + d[31:24];
  endfunction
  function automatic logic [31:0] lstep(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
  endfunction
  task automatic start_a(input logic [1:0] m, input logic [15:0] f);
    @(negedge clk);
    st_a = 1'b1; md_a = m; fr_a = f;
    @(negedge clk);
    st_a = 1'b0;
  endtask
  task automatic wait_a(input int lim);
    int n = 0;
    while (!done_a && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("done_a", done_a, 1);
  endtask
  task automatic push_ramp_a(input int first, input int cnt);
    for (int i = first; i < first + cnt; i++) q_a.push_back(32'(i));
  endtask
  // scoreboard monitors: pop expected beats and frame checksums as the DUTs produce them
  initial begin
    pst_a = 1'b0; pd_a = '0; pfc_a = '0; pfc_b = '0; pb_b = 1'b0; prr_b = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (pst_a && busy_a) begin
          chk("hold_valid_a", sv_a, 1);
          chk("hold_data_a", sd_a, pd_a);
        end
        if (sv_a && sri_a) chk("stim_a", sd_a, q_a.size() ? q_a.pop_front() : 32'hxxxx_xxxx);
        if (fc_a != pfc_a && fc_a != 16'd0) begin
          chk("frame_step_a", fc_a, pfc_a + 16'd1);
          chk("led_a", led_a, l_a.size() ? l_a.pop_front() : 8'hxx);
        end
        if (sv_b && rr_b) chk("stim_b", sd_b, q_b.size() ? q_b.pop_front() : 32'hxxxx_xxxx);
        if (fc_b != pfc_b && fc_b != 16'd0) chk("led_b", led_b, l_b.size() ? l_b.pop_front() : 8'hxx);
        if (busy_b && pb_b) chk("ready_alt_b", rr_b, !prr_b);
      end
      pst_a = !rst && sv_a && !sri_a;
      pd_a = sd_a; pfc_a = fc_a; pfc_b = fc_b; pb_b = busy_b; prr_b = rr_b;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [3:0] pat;
    logic [31:0] x;
    logic [7:0] s;
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_timeout", to_a, 0);
    chk("rst_valid", sv_a, 0);
    chk("rst_data", sd_a, 0);
    chk("rst_led", led_a, 0);
    chk("rst_fcnt", fc_a, 0);
    chk("rst_rready", rr_a, 0);
    // two ramp frames, free-flowing
    push_ramp_a(0, 8);
    l_a.push_back(8'd6); l_a.push_back(8'd22);
    start_a(2'd0, 16'd2);
    #1;
    chk("start_busy", busy_a, 1);
    chk("start_valid", sv_a, 1);
    wait_a(100);
    #1;
    chk("t1_fcnt", fc_a, 2);
    chk("t1_led", led_a, 8'd22);
    chk("t1_busy", busy_a, 0);
    chk("t1_drained", 32'(q_a.size() + l_a.size()), 0);
    // stalled stimulus with ready pattern 1,0,0,1
    push_ramp_a(0, 4);
    l_a.push_back(8'd6);
    start_a(2'd0, 16'd1);
    pat = 4'b1001;
    n = 0;
    while (!done_a && n < 40) begin
      @(negedge clk);
      sr_a = pat[n % 4];
      n++;
    end
    sr_a = 1'b1;
    wait_a(20);
    #1;
    chk("t2_led", led_a, 8'd6);
    chk("t2_drained", 32'(q_a.size() + l_a.size()), 0);
    // masked result ready on the second instance
    for (int i = 0; i < 8; i++) q_b.push_back(32'(i));
    l_b.push_back(8'd6); l_b.push_back(8'd22);
    @(negedge clk);
    st_b = 1'b1; md_b = 2'd0; fr_b = 16'd2;
    @(negedge clk);
    st_b = 1'b0;
    n = 0;
    while (!done_b && n < 100) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk("t3_done", done_b, 1);
    chk("t3_fcnt", fc_b, 2);
    chk("t3_led", led_b, 8'd22);
    chk("t3_timeout", to_b, 0);
    chk("t3_drained", 32'(q_b.size() + l_b.size()), 0);
    // impulse frame
    q_a.push_back(32'h0001_0000); q_a.push_back(0); q_a.push_back(0); q_a.push_back(0);
    l_a.push_back(8'd1);
    start_a(2'd2, 16'd1);
    wait_a(40);
    #1;
    chk("t4_led", led_a, 8'd1);
    chk("t4_drained", 32'(q_a.size() + l_a.size()), 0);
    // watchdog abort with stimulus never accepted; a start pulse mid-run must be ignored
    sr_a = 1'b0;
    start_a(2'd0, 16'd1);
    repeat (4) @(negedge clk);
    st_a = 1'b1; fr_a = 16'd0;
    @(negedge clk);
    st_a = 1'b0; fr_a = 16'd1;
    #1;
    chk("t5_ign_done", done_a, 0);
    chk("t5_ign_busy", busy_a, 1);
    repeat (10) @(negedge clk);
    #1;
    chk("t5_pre_timeout", to_a, 0);
    chk("t5_pre_busy", busy_a, 1);
    @(negedge clk);
    #1;
    chk("t5_timeout", to_a, 1);
    chk("t5_done", done_a, 1);
    chk("t5_busy", busy_a, 0);
    chk("t5_valid", sv_a, 0);
    chk("t5_fcnt", fc_a, 0);
    sr_a = 1'b1;
    // reset mid-frame then an LFSR run
    push_ramp_a(0, 8);
    start_a(2'd0, 16'd2);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q_a.delete(); l_a.delete();
    x = 32'h1; s = '0;
    for (int i = 0; i < 4; i++) begin
      q_a.push_back(x);
      s = s + bsum(x);
      x = lstep(x);
    end
    l_a.push_back(s);
    #1;
    chk("t6_valid", sv_a, 0);
    chk("t6_busy", busy_a, 0);
    chk("t6_fcnt", fc_a, 0);
    chk("t6_led", led_a, 0);
    start_a(2'd3, 16'd1);
    #1;
    chk("t6_lfsr_first", sd_a, 32'h0000_0001);
    wait_a(40);
    #1;
    chk("t6_lfsr_led", led_a, s);
    chk("t6_drained", 32'(q_a.size() + l_a.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
